pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- 16-bit 6502 program counter (PCL/PCH) that sits directly upstream of the internal bus instances.
- Sources driver slots for the ADL, ADH and DB buses and loads back from the resolved ADL/ADH bus values.
- Incrementer with PCL-to-PCH carry.
- All state changes happen on one clock edge, gated by rdy.

Parameters:
RESET_PC, 16'hFFFC, PC value after reset (reset vector address; the microcode fetches the vector from here).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  one clock; reset is synchronous and active-low.
rdy  in  1  1 = advance, 0 = hold all state.
adl_in  in  8  resolved ADL bus value (output of the ADL bus instance).
adh_in  in  8  resolved ADH bus value.
pcl_sel_adl  in  1  PCL source: 1 = adl_in, 0 = current PCL.
pch_sel_adh  in  1  PCH source: 1 = adh_in, 0 = current PCH.
pc_inc  in  1  add 1 to the selected source.
pcl_to_adl  in  1  drive PCL onto ADL.
pch_to_adh  in  1  drive PCH onto ADH.
pcl_to_db  in  1  drive PCL onto DB.
pch_to_db  in  1  drive PCH onto DB.
adl_drv_value  out  8  ADL driver slot value.
adl_drv_en  out  1  ADL driver slot enable.
adh_drv_value  out  8  ADH driver slot value.
adh_drv_en  out  1  ADH driver slot enable.
db_drv_value  out  8  DB driver slot value.
db_drv_en  out  1  DB driver slot enable.
pc  out  16  current {PCH,PCL}, for debug and trace.
drive_conflict  out  1  pcl_to_db and pch_to_db both asserted (combinational).

Behaviour:
- Registers pcl and pch reset to RESET_PC[7:0] and RESET_PC[15:8] on a clk edge with rst_n=0.
  - Reset overrides rdy and all controls.
  - Reset asserted mid-sequence discards any load or increment in that cycle.
- Next-state logic applies on a clk edge with rst_n=1 and rdy=1:
  - src_l = pcl_sel_adl ? adl_in : pcl
  - src_h = pch_sel_adh ? adh_in : pch
  - {carry, pcl_next} = src_l + pc_inc (9-bit sum).
  - pch_next = src_h + carry (8-bit, wraps).
  - Carry is generated only when pc_inc=1 and src_l=8'hFF.
- Wrap-around: 16'hFFFF with inc gives 16'h0000. 16'h12FF with inc gives 16'h1300.
- Loaded-and-incremented: the increment applies to the loaded value, e.g. adl_in=FF, adh_in=80, both selects and inc give 16'h8100.
- With rdy=0, pcl and pch hold regardless of selects and inc. Drive outputs remain live, since they are combinational from registers and enables.
- Drive outputs are combinational from the current registers; there is zero latency. A value loaded at edge N is driven from edge N onward.
  - adl_drv_en = pcl_to_adl; adl_drv_value = pcl
  - adh_drv_en = pch_to_adh; adh_drv_value = pch
  - db_drv_en = pcl_to_db | pch_to_db
  - db_drv_value: pcl if only pcl_to_db is set; pch if only pch_to_db is set; pcl & pch if both are set (NMOS wired-AND); 8'h00 if neither is set.
- When an enable is 0, its drv_value is still the register value (don't-care to the bus); the verifier checks value only when the enable is high.
- Read-before-write is the same-cycle rule: drivers present the old PC while loading from the same bus. A PC-to-ADL/ADL-to-PC loop therefore latches the old PCL (+inc).
- pc = {pch, pcl} registered; its reset value is RESET_PC.
- There is no X-propagation into the registers. Bus inputs are sampled only when the corresponding select is 1.

Decomposition:
- Package cpu6502_pkg:
  - typedef byte_t (logic [7:0]) and addr_t (logic [15:0]).
  - Constants VEC_NMI=16'hFFFA, VEC_RESET=16'hFFFC, VEC_IRQ=16'hFFFE; RESET_PC defaults to VEC_RESET.
- One sub-module, pc_half, instantiated twice (low and high) and chained by carry. It contains:
  - 8-bit register
  - source mux
  - +carry_in adder with carry_out
  - reset value parameter
- The top level adds DB drive merging and conflict detection.

Test Plan:
- Reset: rst_n=0 for 2 cycles with pc_inc=1 -> pc=16'hFFFC. No drive enables are set -> all drv_en=0.
- Increment chain: after reset, pc_inc=1 for 5 cycles -> pc steps FFFD, FFFE, FFFF, 0000, 0001. Carry occurs at FFFF->0000.
- Load without inc: adl_in=34, adh_in=12, both selects set, pc_inc=0 -> pc=16'h1234 next cycle. With pcl_to_adl=1 in the following cycle -> adl_drv_value=34, adl_drv_en=1.
- Load with carry: pc=0000; adl_in=FF, pcl_sel_adl=1, pch_sel_adh=0, pc_inc=1 -> pc=16'h0100.
- Stall and reset priority:
  - pc=1234, rdy=0, pc_inc=1 for 3 cycles -> pc stays 1234, while pch_to_adh=1 shows 12.
  - Then rst_n=0 with rdy=0 -> pc=FFFC.
- DB conflict: pc=16'hF00F, pcl_to_db=pch_to_db=1 -> db_drv_value=8'h00, db_drv_en=1, drive_conflict=1.
  - pcl_to_db alone -> 8'h0F, drive_conflict=0.

Source files
------------

// File: rtl/cpu6502_pkg.sv
// Shared types and vector addresses for the 6502 datapath blocks.
package cpu6502_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] addr_t;

  localparam addr_t VEC_NMI   = 16'hFFFA;
  localparam addr_t VEC_RESET = 16'hFFFC;
  localparam addr_t VEC_IRQ   = 16'hFFFE;

endpackage

// File: rtl/pc_half.sv
// One byte of the program counter: source mux, +carry_in incrementer, register.
module pc_half
  import cpu6502_pkg::*;
#(
  parameter byte_t RESET_VAL = 8'h00
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  rdy,
  input  logic  sel_bus,
  input  byte_t bus_in,
  input  logic  carry_in,
  output byte_t q,
  output logic  carry_out
);

  byte_t      q_q;
  byte_t      q_d;
  byte_t      src;
  logic [8:0] sum;

  // The bus is only looked at when selected, so an undriven bus cannot leak in.
  always_comb begin
    src       = sel_bus ? bus_in : q_q;
    sum       = {1'b0, src} + {8'b0, carry_in};
    q_d       = sum[7:0];
    carry_out = sum[8];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is tested first so it beats rdy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else if (rdy) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pc_unit.sv
// 6502 program counter: two chained byte halves plus ADL/ADH/DB driver slots.
module pc_unit
  import cpu6502_pkg::*;
#(
  parameter addr_t RESET_PC = VEC_RESET
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  adl_in,
  input  logic [7:0]  adh_in,
  input  logic        pcl_sel_adl,
  input  logic        pch_sel_adh,
  input  logic        pc_inc,
  input  logic        pcl_to_adl,
  input  logic        pch_to_adh,
  input  logic        pcl_to_db,
  input  logic        pch_to_db,
  output logic [7:0]  adl_drv_value,
  output logic        adl_drv_en,
  output logic [7:0]  adh_drv_value,
  output logic        adh_drv_en,
  output logic [7:0]  db_drv_value,
  output logic        db_drv_en,
  output logic [15:0] pc,
  output logic        drive_conflict
);

  byte_t pcl;
  byte_t pch;
  logic  carry_l;
  logic  unused_carry_h;

  pc_half #(.RESET_VAL(RESET_PC[7:0])) u_pcl (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .sel_bus   (pcl_sel_adl),
    .bus_in    (adl_in),
    .carry_in  (pc_inc),
    .q         (pcl),
    .carry_out (carry_l)
  );

  pc_half #(.RESET_VAL(RESET_PC[15:8])) u_pch (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .sel_bus   (pch_sel_adh),
    .bus_in    (adh_in),
    .carry_in  (carry_l),
    .q         (pch),
    .carry_out (unused_carry_h)
  );

  assign adl_drv_en    = pcl_to_adl;
  assign adl_drv_value = pcl;
  assign adh_drv_en    = pch_to_adh;
  assign adh_drv_value = pch;
  assign db_drv_en     = pcl_to_db | pch_to_db;
  assign drive_conflict = pcl_to_db & pch_to_db;
  assign pc            = {pch, pcl};

  // Two PC bytes on DB at once resolve as the NMOS wired-AND of both.
  // NOTE: the default arm keeps this combinational block latch-free.
  always_comb begin
    unique case ({pcl_to_db, pch_to_db})
      2'b10:   db_drv_value = pcl;
      2'b01:   db_drv_value = pch;
      2'b11:   db_drv_value = pcl & pch;
      default: db_drv_value = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed checks of pc_unit: reset, increment/carry, loads, stall, DB merge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic [7:0]  adl_in, adh_in;
  logic        pcl_sel_adl, pch_sel_adh, pc_inc;
  logic        pcl_to_adl, pch_to_adh, pcl_to_db, pch_to_db;
  logic [7:0]  adl_drv_value, adh_drv_value, db_drv_value;
  logic        adl_drv_en, adh_drv_en, db_drv_en, drive_conflict;
  logic [15:0] pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .adl_in         (adl_in),
    .adh_in         (adh_in),
    .pcl_sel_adl    (pcl_sel_adl),
    .pch_sel_adh    (pch_sel_adh),
    .pc_inc         (pc_inc),
    .pcl_to_adl     (pcl_to_adl),
    .pch_to_adh     (pch_to_adh),
    .pcl_to_db      (pcl_to_db),
    .pch_to_db      (pch_to_db),
    .adl_drv_value  (adl_drv_value),
    .adl_drv_en     (adl_drv_en),
    .adh_drv_value  (adh_drv_value),
    .adh_drv_en     (adh_drv_en),
    .db_drv_value   (db_drv_value),
    .db_drv_en      (db_drv_en),
    .pc             (pc),
    .drive_conflict (drive_conflict)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] l, input logic inc);
    adl_in = l; adh_in = h;
    pcl_sel_adl = 1'b1; pch_sel_adh = 1'b1; pc_inc = inc;
    step();
    pcl_sel_adl = 1'b0; pch_sel_adh = 1'b0; pc_inc = 1'b0;
  endtask

  logic [15:0] inc_exp [5] = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  initial begin
    rst_n = 1'b0; rdy = 1'b1; adl_in = 8'h00; adh_in = 8'h00;
    pcl_sel_adl = 1'b0; pch_sel_adh = 1'b0; pc_inc = 1'b1;
    pcl_to_adl = 1'b0; pch_to_adh = 1'b0; pcl_to_db = 1'b0; pch_to_db = 1'b0;

    step(); step();
    check("reset_pc", pc, 16'hFFFC);
    check("reset_adl_en", {15'b0, adl_drv_en}, 16'h0);
    check("reset_adh_en", {15'b0, adh_drv_en}, 16'h0);
    check("reset_db_en", {15'b0, db_drv_en}, 16'h0);
    check("reset_conflict", {15'b0, drive_conflict}, 16'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("inc_%0d", i), pc, inc_exp[i]);
    end
    pc_inc = 1'b0;

    load(8'h12, 8'h34, 1'b0);
    check("load_noinc", pc, 16'h1234);
    pcl_to_adl = 1'b1;
    #1;
    check("adl_drv_value", {8'h00, adl_drv_value}, 16'h0034);
    check("adl_drv_en", {15'b0, adl_drv_en}, 16'h1);
    step();
    check("hold_no_ctrl", pc, 16'h1234);
    pcl_to_adl = 1'b0;

    load(8'h00, 8'h00, 1'b0);
    check("load_zero", pc, 16'h0000);
    adl_in = 8'hFF; pcl_sel_adl = 1'b1; pch_sel_adh = 1'b0; pc_inc = 1'b1;
    step();
    check("load_carry", pc, 16'h0100);
    pcl_sel_adl = 1'b0; pc_inc = 1'b0;

    load(8'h12, 8'hFF, 1'b0);
    pc_inc = 1'b1;
    step();
    check("wrap_12ff", pc, 16'h1300);
    pc_inc = 1'b0;

    load(8'h80, 8'hFF, 1'b1);
    check("load_and_inc", pc, 16'h8100);

    // Read-before-write: drivers show old PCL while PCL reloads from ADL.
    pcl_to_adl = 1'b1; adl_in = 8'h00; pcl_sel_adl = 1'b1; pc_inc = 1'b1;
    #1;
    check("rbw_old_pcl", {8'h00, adl_drv_value}, 16'h0000);
    step();
    check("rbw_latched", pc, 16'h8101);
    pcl_to_adl = 1'b0; pcl_sel_adl = 1'b0; pc_inc = 1'b0;

    load(8'h12, 8'h34, 1'b0);
    rdy = 1'b0; pc_inc = 1'b1; pch_to_adh = 1'b1;
    pcl_sel_adl = 1'b1; adl_in = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_pc_%0d", i), pc, 16'h1234);
      check($sformatf("stall_adh_%0d", i), {7'b0, adh_drv_en, adh_drv_value}, 16'h0112);
    end
    rst_n = 1'b0;
    step();
    check("reset_over_stall", pc, 16'hFFFC);
    rst_n = 1'b1; rdy = 1'b1; pc_inc = 1'b0; pch_to_adh = 1'b0; pcl_sel_adl = 1'b0;

    load(8'hF0, 8'h0F, 1'b0);
    check("load_f00f", pc, 16'hF00F);
    pcl_to_db = 1'b1; pch_to_db = 1'b1;
    #1;
    check("db_both_val", {8'h00, db_drv_value}, 16'h0000);
    check("db_both_en", {15'b0, db_drv_en}, 16'h1);
    check("db_both_conflict", {15'b0, drive_conflict}, 16'h1);
    pcl_to_db = 1'b0;
    #1;
    check("db_pch_val", {8'h00, db_drv_value}, 16'h00F0);
    pcl_to_db = 1'b1; pch_to_db = 1'b0;
    #1;
    check("db_pcl_val", {8'h00, db_drv_value}, 16'h000F);
    check("db_pcl_conflict", {15'b0, drive_conflict}, 16'h0);
    pcl_to_db = 1'b0;
    #1;
    check("db_none", {7'b0, db_drv_en, db_drv_value}, 16'h0000);

    adl_in = 8'h55; adh_in = 8'h66; pcl_sel_adl = 1'b1; pch_sel_adh = 1'b1; pc_inc = 1'b1;
    rst_n = 1'b0;
    step();
    check("reset_discards_load", pc, 16'hFFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
